// File: rtl/mem_bank_pkg.sv
// Shared definitions for the mem_bank_sram slice: AXI ATOP encodings, ALU opcodes,
// FSM state type and the response-pipeline control struct.
package mem_bank_pkg;

    // atop[5:4] selects the atomic class; atop[2:0] is the arithmetic op
    localparam logic [1:0] ATOP_NONE    = 2'b00;
    localparam logic [1:0] ATOP_STORE   = 2'b01;
    localparam logic [1:0] ATOP_LOAD    = 2'b10;
    localparam logic [1:0] ATOP_SWPCMP  = 2'b11;

    localparam logic [5:0] ATOP_SWAP    = 6'b110000;
    localparam logic [5:0] ATOP_CMP     = 6'b110001;

    localparam logic [2:0] AMO_ADD  = 3'd0;
    localparam logic [2:0] AMO_CLR  = 3'd1;
    localparam logic [2:0] AMO_EOR  = 3'd2;
    localparam logic [2:0] AMO_SET  = 3'd3;
    localparam logic [2:0] AMO_SMAX = 3'd4;
    localparam logic [2:0] AMO_SMIN = 3'd5;
    localparam logic [2:0] AMO_UMAX = 3'd6;
    localparam logic [2:0] AMO_UMIN = 3'd7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_AMO_WR = 1'b1
    } state_e;

    // First response stage: data is resolved from sram_rdata_i one cycle after grant
    typedef struct packed {
        logic valid;
        logic use_rdata;
    } resp_t;

    // Compare and reserved encodings fall through as plain reads
    function automatic logic atop_is_amo(input logic [5:0] atop);
        return (atop[5:4] == ATOP_STORE) || (atop[5:4] == ATOP_LOAD) || (atop == ATOP_SWAP);
    endfunction

endpackage

// File: rtl/mem_bank_sram_if.sv
// Request/response bus of the memory bank, with master (requester) and slave (bank) views.
interface mem_bank_sram_if
    import mem_bank_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32
) ();

    logic                   req;
    logic                   gnt;
    logic [AddrWidth-1:0]   addr;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] strb;
    logic [5:0]             atop;
    logic                   we;
    logic                   rvalid;
    logic [DataWidth-1:0]   rdata;

    modport master (
        output req, addr, wdata, strb, atop, we,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, addr, wdata, strb, atop, we,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_bank_amo_alu.sv
// Combinational AMO ALU: new word from the old SRAM word and the request operand.
module mem_bank_amo_alu
    import mem_bank_pkg::*;
#(
    parameter int unsigned DataWidth = 32
) (
    input  logic [DataWidth-1:0] i_old,
    input  logic [DataWidth-1:0] i_operand,
    input  logic [2:0]           i_op,
    input  logic                 i_swap,
    output logic [DataWidth-1:0] o_result
);

    always_comb begin
        o_result = i_operand;
        if (!i_swap) begin
            case (i_op)
                AMO_ADD:  o_result = i_old + i_operand;
                AMO_CLR:  o_result = i_old & ~i_operand;
                AMO_EOR:  o_result = i_old ^ i_operand;
                AMO_SET:  o_result = i_old | i_operand;
                AMO_SMAX: o_result = ($signed(i_old) > $signed(i_operand)) ? i_old : i_operand;
                AMO_SMIN: o_result = ($signed(i_old) < $signed(i_operand)) ? i_old : i_operand;
                AMO_UMAX: o_result = (i_old > i_operand) ? i_old : i_operand;
                AMO_UMIN: o_result = (i_old < i_operand) ? i_old : i_operand;
                default:  o_result = i_operand;
            endcase
        end
    end

endmodule

// File: rtl/mem_bank_sram.sv
// Memory bank front-end to a single-port SRAM with in-order responses.
// Atomics (read-modify-write through mem_bank_amo_alu) are built only when MEM_BANK_ATOP_EN is defined.
module mem_bank_sram
    import mem_bank_pkg::*;
#(
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 1024,
    parameter int unsigned RespRegs  = 0,
    parameter int unsigned HideStrb  = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         mem_req_i,
    output logic                         mem_gnt_o,
    input  logic [AddrWidth-1:0]         mem_addr_i,
    input  logic [DataWidth-1:0]         mem_wdata_i,
    input  logic [DataWidth/8-1:0]       mem_strb_i,
    input  logic [5:0]                   mem_atop_i,
    input  logic                         mem_we_i,
    output logic                         mem_rvalid_o,
    output logic [DataWidth-1:0]         mem_rdata_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NumWords)-1:0]  sram_addr_o,
    output logic [DataWidth-1:0]         sram_wdata_o,
    output logic [DataWidth/8-1:0]       sram_be_o,
    input  logic [DataWidth-1:0]         sram_rdata_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned WordIdxW  = $clog2(NumWords);
    localparam int unsigned ByteOffW  = $clog2(StrbWidth);

    logic [WordIdxW-1:0] w_req_idx;
    logic                w_gnt;
    logic                w_plain_wr;
    logic                w_hidden;
    logic                w_resp_rd;
    logic                w_unused_bits;

    assign w_req_idx     = mem_addr_i[ByteOffW +: WordIdxW];
    assign w_unused_bits = ^{mem_addr_i, mem_atop_i};

`ifdef MEM_BANK_ATOP_EN
    state_e              r_state;
    logic [WordIdxW-1:0] r_amo_idx;
    logic [DataWidth-1:0] r_amo_operand;
    logic [StrbWidth-1:0] r_amo_strb;
    logic [2:0]          r_amo_op;
    logic                r_amo_swap;
    logic [DataWidth-1:0] w_amo_result;
    logic                w_is_amo;

    assign w_is_amo   = atop_is_amo(mem_atop_i);
    assign w_gnt      = mem_req_i && (r_state == ST_IDLE) && !rst_i;
    assign w_plain_wr = mem_we_i && (mem_atop_i[5:4] == ATOP_NONE);
    // ATOMICSTORE answers zero; LOAD and SWAP return the old word
    assign w_resp_rd  = w_is_amo ? (mem_atop_i[5:4] != ATOP_STORE) : !w_plain_wr;

    mem_bank_amo_alu #(
        .DataWidth (DataWidth)
    ) u_amo_alu (
        .i_old     (sram_rdata_i),
        .i_operand (r_amo_operand),
        .i_op      (r_amo_op),
        .i_swap    (r_amo_swap),
        .o_result  (w_amo_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_amo_idx     <= '0;
            r_amo_operand <= '0;
            r_amo_strb    <= '0;
            r_amo_op      <= '0;
            r_amo_swap    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gnt && w_is_amo) begin
                        r_state       <= ST_AMO_WR;
                        r_amo_idx     <= w_req_idx;
                        r_amo_operand <= mem_wdata_i;
                        r_amo_strb    <= mem_strb_i;
                        r_amo_op      <= mem_atop_i[2:0];
                        r_amo_swap    <= (mem_atop_i == ATOP_SWAP);
                    end
                end
                ST_AMO_WR: r_state <= ST_IDLE;
                default:   r_state <= ST_IDLE;
            endcase
        end
    end
`else
    assign w_gnt      = mem_req_i && !rst_i;
    assign w_plain_wr = mem_we_i;
    assign w_resp_rd  = !mem_we_i;
`endif

    assign w_hidden  = (HideStrb != 0) && w_plain_wr && (mem_strb_i == '0);
    assign mem_gnt_o = w_gnt;

    always_comb begin
        sram_req_o   = w_gnt && !w_hidden;
        sram_we_o    = w_plain_wr;
        sram_addr_o  = w_req_idx;
        sram_wdata_o = mem_wdata_i;
        sram_be_o    = mem_strb_i;
`ifdef MEM_BANK_ATOP_EN
        // Write-back slot: reset in this cycle drops the write
        if (r_state == ST_AMO_WR) begin
            sram_req_o   = !rst_i;
            sram_we_o    = 1'b1;
            sram_addr_o  = r_amo_idx;
            sram_wdata_o = w_amo_result;
            sram_be_o    = r_amo_strb;
        end
`endif
    end

    resp_t r_resp;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_resp <= '0;
        end else begin
            r_resp.valid     <= w_gnt;
            r_resp.use_rdata <= w_gnt && w_resp_rd;
        end
    end

    logic [RespRegs:0]                w_stage_vld;
    logic [RespRegs:0][DataWidth-1:0] w_stage_data;

    assign w_stage_vld[0]  = r_resp.valid;
    assign w_stage_data[0] = r_resp.use_rdata ? sram_rdata_i : '0;

    for (genvar gi = 1; gi <= RespRegs; gi++) begin : g_resp
        logic                 r_vld;
        logic [DataWidth-1:0] r_data;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_vld  <= 1'b0;
                r_data <= '0;
            end else begin
                r_vld  <= w_stage_vld[gi-1];
                r_data <= w_stage_data[gi-1];
            end
        end

        assign w_stage_vld[gi]  = r_vld;
        assign w_stage_data[gi] = r_data;
    end

    assign mem_rvalid_o = w_stage_vld[RespRegs] && !rst_i;
    assign mem_rdata_o  = rst_i ? '0 : w_stage_data[RespRegs];

endmodule

// File: tb/tb_mem_bank_sram.sv
// Scoreboard bench for mem_bank_sram with a behavioural SRAM; atomic vectors run when MEM_BANK_ATOP_EN is defined.
module tb_mem_bank_sram;
    import mem_bank_pkg::*;

    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;
    localparam int unsigned NWORDS    = 64;
    localparam int unsigned RESP_REGS = 1;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
        string         name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bank_sram_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    logic                      sram_req;
    logic                      sram_we;
    logic [$clog2(NWORDS)-1:0] sram_addr;
    logic [DW-1:0]             sram_wdata;
    logic [DW/8-1:0]           sram_be;
    logic [DW-1:0]             sram_rdata = '0;
    logic [DW-1:0]             mem [NWORDS];

    mem_bank_sram #(
        .AddrWidth (AW),
        .DataWidth (DW),
        .NumWords  (NWORDS),
        .RespRegs  (RESP_REGS),
        .HideStrb  (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (bus.req),
        .mem_gnt_o    (bus.gnt),
        .mem_addr_i   (bus.addr),
        .mem_wdata_i  (bus.wdata),
        .mem_strb_i   (bus.strb),
        .mem_atop_i   (bus.atop),
        .mem_we_i     (bus.we),
        .mem_rvalid_o (bus.rvalid),
        .mem_rdata_o  (bus.rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata)
    );

    // Behavioural single-port SRAM, read data one cycle after enable
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < DW/8; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every presented response is popped and compared
    always @(negedge clk) begin
        if (bus.rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_rvalid: got data=%h at cycle %0d, required no response", bus.rdata, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("resp %s: data=%h exp=%h cycle=%0d due=%0d", e.name, bus.rdata, e.data, cyc, e.due);
                if (bus.rdata !== e.data) begin
                    n_errors++;
                    $display("FAIL %s_data: got %h, required %h", e.name, bus.rdata, e.data);
                end
                n_checks++;
                if (cyc != e.due) begin
                    n_errors++;
                    $display("FAIL %s_latency: got cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end
            end
        end
    end

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Drive one request; expect the grant after exp_wait stalled cycles
    task automatic issue(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic [3:0] strb,
                         input logic [5:0] atop, input logic we, input logic [DW-1:0] exp_data,
                         input int exp_wait, input logic exp_sreq, input string name);
        int waits = 0;
        bit done  = 0;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.addr  = addr;
        bus.wdata = wdata;
        bus.strb  = strb;
        bus.atop  = atop;
        bus.we    = we;
        while (!done) begin
            #1;
            if (bus.gnt) begin
                check({name, "_sram_req"}, {31'd0, sram_req}, {31'd0, exp_sreq});
                exp_q.push_back('{exp_data, cyc + 1 + RESP_REGS, name});
                done = 1;
            end else if (waits >= 8) begin
                n_checks++;
                n_errors++;
                $display("FAIL %s_grant_timeout: got no grant in %0d cycles, required grant", name, waits);
                done = 1;
            end
            if (!done) begin
                waits++;
                @(negedge clk);
            end
        end
        check({name, "_stall"}, waits, exp_wait);
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req = 1'b0;
        bus.we  = 1'b0;
        bus.atop = 6'b0;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;
        bus.req   = 1'b1;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.strb  = '0;
        bus.atop  = '0;
        bus.we    = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset_gnt", {31'd0, bus.gnt}, 32'd0);
        check("reset_sram_req", {31'd0, sram_req}, 32'd0);
        check("reset_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("reset_rdata", bus.rdata, 32'd0);
        bus.req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        issue(32'h10, 32'hDEADBEEF, 4'hF, 6'b0, 1'b1, 32'h0,        0, 1'b1, "wr_deadbeef");
        issue(32'h10, 32'h0,        4'hF, 6'b0, 1'b0, 32'hDEADBEEF, 0, 1'b1, "rd_deadbeef");
        issue(32'h00, 32'h11223344, 4'h5, 6'b0, 1'b1, 32'h0,        0, 1'b1, "wr_strb0101");
        issue(32'h00, 32'h0,        4'hF, 6'b0, 1'b0, 32'h00220044, 0, 1'b1, "rd_strb0101");
        issue(32'h10, 32'hFFFFFFFF, 4'h0, 6'b0, 1'b1, 32'h0,        0, 1'b0, "wr_hidden");
        issue(32'h10, 32'h0,        4'hF, 6'b0, 1'b0, 32'hDEADBEEF, 0, 1'b1, "rd_after_hidden");
        issue(32'h110, 32'h0,       4'hF, 6'b0, 1'b0, 32'hDEADBEEF, 0, 1'b1, "rd_alias_high");
        issue(32'h13, 32'h0,        4'hF, 6'b0, 1'b0, 32'hDEADBEEF, 0, 1'b1, "rd_alias_low");
        issue(32'h20, 32'hA5A50001, 4'hF, 6'b0, 1'b1, 32'h0,        0, 1'b1, "b2b_wr0");
        issue(32'h24, 32'h5A5A0002, 4'hF, 6'b0, 1'b1, 32'h0,        0, 1'b1, "b2b_wr1");
        issue(32'h20, 32'h0,        4'hF, 6'b0, 1'b0, 32'hA5A50001, 0, 1'b1, "b2b_rd0");
        issue(32'h24, 32'h0,        4'hF, 6'b0, 1'b0, 32'h5A5A0002, 0, 1'b1, "b2b_rd1");

`ifdef MEM_BANK_ATOP_EN
        issue(32'h30, 32'h7,        4'hF, 6'b0,      1'b1, 32'h0,        0, 1'b1, "amo_setup7");
        issue(32'h30, 32'h5,        4'hF, 6'b100000, 1'b0, 32'h7,        0, 1'b1, "amo_ld_add");
        issue(32'h30, 32'h0,        4'hF, 6'b0,      1'b0, 32'hC,        1, 1'b1, "amo_add_rd");
        issue(32'h34, 32'hFFFFFFFF, 4'hF, 6'b0,      1'b1, 32'h0,        0, 1'b1, "amo_setup_smax");
        issue(32'h34, 32'h1,        4'hF, 6'b100100, 1'b0, 32'hFFFFFFFF, 0, 1'b1, "amo_smax");
        issue(32'h34, 32'h0,        4'hF, 6'b0,      1'b0, 32'h1,        1, 1'b1, "amo_smax_rd");
        issue(32'h38, 32'hFFFFFFFF, 4'hF, 6'b0,      1'b1, 32'h0,        0, 1'b1, "amo_setup_umax");
        issue(32'h38, 32'h1,        4'hF, 6'b100110, 1'b0, 32'hFFFFFFFF, 0, 1'b1, "amo_umax");
        issue(32'h38, 32'h0,        4'hF, 6'b0,      1'b0, 32'hFFFFFFFF, 1, 1'b1, "amo_umax_rd");
        issue(32'h30, 32'hABCD,     4'hF, 6'b110000, 1'b0, 32'hC,        0, 1'b1, "amo_swap");
        issue(32'h30, 32'h0,        4'hF, 6'b0,      1'b0, 32'hABCD,     1, 1'b1, "amo_swap_rd");
        issue(32'h30, 32'h00FF,     4'hF, 6'b010001, 1'b0, 32'h0,        0, 1'b1, "amo_st_clr");
        issue(32'h30, 32'h0,        4'hF, 6'b0,      1'b0, 32'hAB00,     1, 1'b1, "amo_clr_rd");
        issue(32'h30, 32'h0,        4'hF, 6'b110001, 1'b0, 32'hAB00,     0, 1'b1, "amo_cmp_plain");
        issue(32'h30, 32'h0,        4'hF, 6'b0,      1'b0, 32'hAB00,     0, 1'b1, "amo_cmp_rd");
        // Reset lands in the write-back cycle: write and response are dropped
        issue(32'h30, 32'h1,        4'hF, 6'b100000, 1'b0, 32'hAB00,     0, 1'b1, "amo_rst");
        @(negedge clk);
        rst = 1'b1;
        bus.req = 1'b0;
        exp_q.delete();
        #1;
        check("amo_rst_sram_req", {31'd0, sram_req}, 32'd0);
        check("amo_rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        issue(32'h30, 32'h0,        4'hF, 6'b0,      1'b0, 32'hAB00,     0, 1'b1, "amo_rst_rd");
`else
        issue(32'h20, 32'h5,        4'hF, 6'b100000, 1'b0, 32'hA5A50001, 0, 1'b1, "atop_ignored");
        issue(32'h20, 32'h0,        4'hF, 6'b0,      1'b0, 32'hA5A50001, 0, 1'b1, "atop_ignored_rd");
`endif
        idle();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
